// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and access sequencer for a
// single-port synchronous RAM with a registered read path.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_req_N                access request, held until out_gnt_N
//   in_we_N                 1 = write, 0 = read
//   in_addr_N, in_wdata_N   word address and write data of the request
//   out_gnt_N               one-cycle pulse: command is on the RAM pins
//   out_rvalid_N            one-cycle pulse: out_rdata_N holds the read result
//   out_rdata_N             last read result for port N
//   out_mem_address/data    registered RAM address and write data
//   out_mem_rden/wren       registered RAM strobes, never high together
//   in_mem_q                RAM read data
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1   // 1 or 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_req_0,
  input  logic                  in_req_1,
  input  logic                  in_we_0,
  input  logic                  in_we_1,
  input  logic [ADDR_WIDTH-1:0] in_addr_0,
  input  logic [ADDR_WIDTH-1:0] in_addr_1,
  input  logic [DATA_WIDTH-1:0] in_wdata_0,
  input  logic [DATA_WIDTH-1:0] in_wdata_1,
  output logic                  out_gnt_0,
  output logic                  out_gnt_1,
  output logic                  out_rvalid_0,
  output logic                  out_rvalid_1,
  output logic [DATA_WIDTH-1:0] out_rdata_0,
  output logic [DATA_WIDTH-1:0] out_rdata_1,
  output logic [ADDR_WIDTH-1:0] out_mem_address,
  output logic [DATA_WIDTH-1:0] out_mem_data,
  output logic                  out_mem_rden,
  output logic                  out_mem_wren,
  input  logic [DATA_WIDTH-1:0] in_mem_q
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  // Two bits cover both legal latencies.
  localparam logic [1:0] LatLast = 2'(READ_LATENCY - 1);

  state_e                  state_q;
  logic                    last_q;    // port that won the previous arbitration
  logic                    owner_q;   // port owning the access in flight
  logic [1:0]              lat_cnt_q;

  logic                    pick;
  logic                    pick_we;
  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [DATA_WIDTH-1:0]   pick_wdata;

  always_comb begin
    // A tie goes to the port that did not win last time; a lone requester wins.
    pick       = in_req_1 & (~in_req_0 | ~last_q);
    pick_we    = pick ? in_we_1    : in_we_0;
    pick_addr  = pick ? in_addr_1  : in_addr_0;
    pick_wdata = pick ? in_wdata_1 : in_wdata_0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      last_q          <= 1'b1;
      owner_q         <= 1'b0;
      lat_cnt_q       <= '0;
      out_gnt_0       <= 1'b0;
      out_gnt_1       <= 1'b0;
      out_rvalid_0    <= 1'b0;
      out_rvalid_1    <= 1'b0;
      out_rdata_0     <= '0;
      out_rdata_1     <= '0;
      out_mem_address <= '0;
      out_mem_data    <= '0;
      out_mem_rden    <= 1'b0;
      out_mem_wren    <= 1'b0;
    end else begin
      // Grants, valids and strobes are single-cycle; address/data hold.
      out_gnt_0    <= 1'b0;
      out_gnt_1    <= 1'b0;
      out_rvalid_0 <= 1'b0;
      out_rvalid_1 <= 1'b0;
      out_mem_rden <= 1'b0;
      out_mem_wren <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_req_0 || in_req_1) begin
            state_q         <= StIssue;
            last_q          <= pick;
            owner_q         <= pick;
            out_gnt_0       <= ~pick;
            out_gnt_1       <= pick;
            out_mem_address <= pick_addr;
            out_mem_data    <= pick_wdata;
            out_mem_wren    <= pick_we;
            out_mem_rden    <= ~pick_we;
          end
        end
        StIssue: begin
          // The wren register still reflects the latched command here.
          if (out_mem_wren) begin
            state_q <= StIdle;
          end else begin
            state_q   <= StWait;
            lat_cnt_q <= '0;
          end
        end
        StWait: begin
          if (lat_cnt_q == LatLast) begin
            state_q <= StResp;
            if (owner_q) begin
              out_rdata_1  <= in_mem_q;
              out_rvalid_1 <= 1'b1;
            end else begin
              out_rdata_0  <= in_mem_q;
              out_rvalid_0 <= 1'b1;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
